// File: rtl/exe_stage_if.sv
// Execute-stage port bundle: ID/EXE register outputs in, EX/MEM register outputs and stall out.
interface exe_stage_if;
    logic        WriteRegIn;
    logic        MemToRegIn;
    logic        writeMemIn;
    logic        BranchIn;
    logic        RegrtIn;
    logic [2:0]  ALUCIn;
    logic        ALUimmIn;
    logic [31:0] nextAddressIn;
    logic [31:0] R1OutputIn;
    logic [31:0] R2OutputIn;
    logic [31:0] signExtendIn;
    logic [4:0]  rdIn;
    logic [4:0]  rtIn;

    logic        stall;
    logic        WriteRegOut;
    logic        MemToRegOut;
    logic        writeMemOut;
    logic        branchTakenOut;
    logic [31:0] branchTargetOut;
    logic [31:0] aluResultOut;
    logic [31:0] storeDataOut;
    logic [4:0]  destRegOut;
    logic        ovfOut;

    modport master (
        output WriteRegIn, MemToRegIn, writeMemIn, BranchIn, RegrtIn, ALUCIn, ALUimmIn,
               nextAddressIn, R1OutputIn, R2OutputIn, signExtendIn, rdIn, rtIn,
        input  stall, WriteRegOut, MemToRegOut, writeMemOut, branchTakenOut,
               branchTargetOut, aluResultOut, storeDataOut, destRegOut, ovfOut
    );

    modport slave (
        input  WriteRegIn, MemToRegIn, writeMemIn, BranchIn, RegrtIn, ALUCIn, ALUimmIn,
               nextAddressIn, R1OutputIn, R2OutputIn, signExtendIn, rdIn, rtIn,
        output stall, WriteRegOut, MemToRegOut, writeMemOut, branchTakenOut,
               branchTargetOut, aluResultOut, storeDataOut, destRegOut, ovfOut
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage with EX/MEM register and iterative radix-2^MUL_RADIX_BITS multiplier.
// Define EXE_OVF_TRAP_EN to flag ADD/SUB signed overflow and suppress its writeback.
module exe_stage #(
    parameter int MUL_RADIX_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    exe_stage_if.slave bus
);
    localparam int N     = 32 / MUL_RADIX_BITS;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic [31:0]      r_acc;

    logic        r_write_reg;
    logic        r_mem_to_reg;
    logic        r_write_mem;
    logic        r_branch_taken;
    logic [31:0] r_branch_target;
    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_dest_reg;
    logic        r_ovf;

    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [31:0] w_pp;
    logic        w_mul_req;
    logic        w_stall;
    logic        w_trap;

    assign w_op_b    = bus.ALUimmIn ? bus.signExtendIn : bus.R2OutputIn;
    assign w_mul_req = (bus.ALUCIn == 3'b111) && bus.WriteRegIn;
    assign w_stall   = ((r_state == S_IDLE) && w_mul_req) || (r_state == S_RUN);
    assign bus.stall = !rst && w_stall;

`ifdef EXE_OVF_TRAP_EN
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    assign w_sum  = bus.R1OutputIn + w_op_b;
    assign w_diff = bus.R1OutputIn - w_op_b;
    // Overflow when the operands' signs make the true result unrepresentable.
    assign w_trap = ((bus.ALUCIn == 3'b000) && (bus.R1OutputIn[31] == w_op_b[31])
                        && (w_sum[31] != bus.R1OutputIn[31]))
                 || ((bus.ALUCIn == 3'b001) && (bus.R1OutputIn[31] != w_op_b[31])
                        && (w_diff[31] != bus.R1OutputIn[31]));
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns w_alu and no latch is inferred.
        w_alu = '0;
        case (bus.ALUCIn)
            3'b000:  w_alu = bus.R1OutputIn + w_op_b;
            3'b001:  w_alu = bus.R1OutputIn - w_op_b;
            3'b010:  w_alu = bus.R1OutputIn & w_op_b;
            3'b011:  w_alu = bus.R1OutputIn | w_op_b;
            3'b100:  w_alu = bus.R1OutputIn ^ w_op_b;
            3'b101:  w_alu = {31'b0, $signed(bus.R1OutputIn) < $signed(w_op_b)};
            3'b110:  w_alu = ~(bus.R1OutputIn | w_op_b);
            default: w_alu = '0;
        endcase
    end

    // One radix digit of B times the shifted A.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_RADIX_BITS; j++) begin
            if (r_mul_b[j]) w_pp = w_pp + (r_mul_a << j);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_mul_a         <= '0;
            r_mul_b         <= '0;
            r_acc           <= '0;
            r_write_reg     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_write_mem     <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_dest_reg      <= '0;
            r_ovf           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_req) begin
                        r_state <= S_RUN;
                        r_mul_a <= bus.R1OutputIn;
                        r_mul_b <= w_op_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= r_acc + w_pp;
                    r_mul_a <= r_mul_a << MUL_RADIX_BITS;
                    r_mul_b <= r_mul_b >> MUL_RADIX_BITS;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Data fields load every cycle; only the controls are squashed into a bubble.
            r_branch_target <= bus.nextAddressIn + (bus.signExtendIn << 2);
            r_store_data    <= bus.R2OutputIn;
            r_dest_reg      <= bus.RegrtIn ? bus.rtIn : bus.rdIn;
            r_alu_result    <= (r_state == S_DONE) ? r_acc : w_alu;
            if (w_stall) begin
                r_write_reg    <= 1'b0;
                r_mem_to_reg   <= 1'b0;
                r_write_mem    <= 1'b0;
                r_branch_taken <= 1'b0;
                r_ovf          <= 1'b0;
            end else begin
                r_write_reg    <= bus.WriteRegIn && !w_trap;
                r_mem_to_reg   <= bus.MemToRegIn;
                r_write_mem    <= bus.writeMemIn;
                r_branch_taken <= bus.BranchIn && (bus.R1OutputIn == bus.R2OutputIn);
                r_ovf          <= w_trap;
            end
        end
    end

    assign bus.WriteRegOut     = r_write_reg;
    assign bus.MemToRegOut     = r_mem_to_reg;
    assign bus.writeMemOut     = r_write_mem;
    assign bus.branchTakenOut  = r_branch_taken;
    assign bus.branchTargetOut = r_branch_target;
    assign bus.aluResultOut    = r_alu_result;
    assign bus.storeDataOut    = r_store_data;
    assign bus.destRegOut      = r_dest_reg;
    assign bus.ovfOut          = r_ovf;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: radix-1 instance for most scenarios, radix-4 instance for stall length.
module tb_exe_stage;
    localparam int MUL1_STALL = 33;
    localparam int MUL4_STALL = 9;
    localparam int MAX_WAIT   = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if ifc ();
    exe_stage_if ifc4 ();

    exe_stage #(.MUL_RADIX_BITS(1)) u_dut  (.clk(clk), .rst(rst), .bus(ifc));
    exe_stage #(.MUL_RADIX_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(ifc4));

    typedef struct {
        logic [2:0]  aluc;
        logic [31:0] r1, r2, sx, na;
        logic        imm, wr, m2r, wm, br, regrt;
        logic [4:0]  rd, rt;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] res, tgt, sd;
        logic        wr, m2r, wm, bt, ovf;
        logic [4:0]  dest;
        int          stall_cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t mk(input logic [2:0] aluc, input logic [31:0] r1, r2, sx,
                                 input logic imm, wr, br);
        stim_t s;
        s.aluc = aluc; s.r1 = r1; s.r2 = r2; s.sx = sx; s.imm = imm; s.wr = wr; s.br = br;
        s.na = 32'h0000_0100; s.m2r = 1'b0; s.wm = 1'b0; s.regrt = 1'b0;
        s.rd = 5'd3; s.rt = 5'd9;
        return s;
    endfunction

    // Reference model written from the instruction semantics.
    function automatic exp_t model(input stim_t s, input string name);
        exp_t        e;
        logic [31:0] b;
        b = s.imm ? s.sx : s.r2;
        e.name = name;
        e.stall_cycles = 0;
        case (s.aluc)
            3'b000:  e.res = s.r1 + b;
            3'b001:  e.res = s.r1 - b;
            3'b010:  e.res = s.r1 & b;
            3'b011:  e.res = s.r1 | b;
            3'b100:  e.res = s.r1 ^ b;
            3'b101:  e.res = ($signed(s.r1) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  e.res = ~(s.r1 | b);
            default: begin
                e.res = s.wr ? s.r1 * b : 32'd0;
                e.stall_cycles = s.wr ? MUL1_STALL : 0;
            end
        endcase
`ifdef EXE_OVF_TRAP_EN
        begin
            longint wide;
            if (s.aluc == 3'b000)      wide = longint'($signed(s.r1)) + longint'($signed(b));
            else if (s.aluc == 3'b001) wide = longint'($signed(s.r1)) - longint'($signed(b));
            else                       wide = 0;
            e.ovf = (wide > 64'sh7FFF_FFFF) || (wide < -64'sh8000_0000);
        end
`else
        e.ovf = 1'b0;
`endif
        e.wr   = s.wr && !e.ovf;
        e.m2r  = s.m2r;
        e.wm   = s.wm;
        e.bt   = s.br && (s.r1 == s.r2);
        e.tgt  = s.na + (s.sx << 2);
        e.sd   = s.r2;
        e.dest = s.regrt ? s.rt : s.rd;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        ifc.ALUCIn = s.aluc; ifc.R1OutputIn = s.r1; ifc.R2OutputIn = s.r2;
        ifc.signExtendIn = s.sx; ifc.nextAddressIn = s.na; ifc.ALUimmIn = s.imm;
        ifc.WriteRegIn = s.wr; ifc.MemToRegIn = s.m2r; ifc.writeMemIn = s.wm;
        ifc.BranchIn = s.br; ifc.RegrtIn = s.regrt; ifc.rdIn = s.rd; ifc.rtIn = s.rt;
    endtask

    task automatic drive(input stim_t s, input string name);
        apply(s);
        sb.push_back(model(s, name));
    endtask

    // Waits out any stall (checking bubbles), then compares the next EX/MEM value with the scoreboard.
    task automatic collect();
        exp_t e;
        int   n;
        n = 0;
        #1;
        while (ifc.stall && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
            checks++;
            if ({ifc.WriteRegOut, ifc.MemToRegOut, ifc.writeMemOut, ifc.branchTakenOut, ifc.ovfOut} !== 5'b0) begin
                errors++;
                $display("FAIL bubble: controls=%b required 00000", {ifc.WriteRegOut, ifc.MemToRegOut,
                         ifc.writeMemOut, ifc.branchTakenOut, ifc.ovfOut});
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: output seen with empty queue, required one entry");
        end else begin
            e = sb.pop_front();
            if (n !== e.stall_cycles) begin errors++; $display("FAIL %s stall_cycles: got %0d required %0d", e.name, n, e.stall_cycles); end
            checks++; if (ifc.aluResultOut !== e.res) begin errors++; $display("FAIL %s aluResultOut: got %h required %h", e.name, ifc.aluResultOut, e.res); end
            checks++; if (ifc.WriteRegOut !== e.wr) begin errors++; $display("FAIL %s WriteRegOut: got %b required %b", e.name, ifc.WriteRegOut, e.wr); end
            checks++; if ({ifc.MemToRegOut, ifc.writeMemOut} !== {e.m2r, e.wm}) begin errors++; $display("FAIL %s mem ctrl: got %b required %b", e.name, {ifc.MemToRegOut, ifc.writeMemOut}, {e.m2r, e.wm}); end
            checks++; if (ifc.branchTakenOut !== e.bt) begin errors++; $display("FAIL %s branchTakenOut: got %b required %b", e.name, ifc.branchTakenOut, e.bt); end
            checks++; if (ifc.branchTargetOut !== e.tgt) begin errors++; $display("FAIL %s branchTargetOut: got %h required %h", e.name, ifc.branchTargetOut, e.tgt); end
            checks++; if (ifc.storeDataOut !== e.sd) begin errors++; $display("FAIL %s storeDataOut: got %h required %h", e.name, ifc.storeDataOut, e.sd); end
            checks++; if (ifc.destRegOut !== e.dest) begin errors++; $display("FAIL %s destRegOut: got %0d required %0d", e.name, ifc.destRegOut, e.dest); end
            checks++; if (ifc.ovfOut !== e.ovf) begin errors++; $display("FAIL %s ovfOut: got %b required %b", e.name, ifc.ovfOut, e.ovf); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t s;
        rst = 1'b1;
        apply(mk(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifc.aluResultOut, ifc.branchTargetOut, ifc.storeDataOut, ifc.destRegOut, ifc.WriteRegOut,
             ifc.MemToRegOut, ifc.writeMemOut, ifc.branchTakenOut, ifc.ovfOut, ifc.stall} !== '0) begin
            errors++;
            $display("FAIL reset_state: result=%h target=%h stall=%b required all zero",
                     ifc.aluResultOut, ifc.branchTargetOut, ifc.stall);
        end
        @(negedge clk);
        rst = 1'b0;
        s = mk(3'b000, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0);
        s.regrt = 1'b1; s.wm = 1'b1;
        drive(s, "add_imm");
        collect();
        // Mid-cycle reset with a pending multiply request: everything drops at once.
        apply(mk(3'b111, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0));
        #1;
        checks++;
        if (ifc.stall !== 1'b1) begin errors++; $display("FAIL mul_req_stall: got %b required 1", ifc.stall); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ifc.aluResultOut, ifc.destRegOut, ifc.WriteRegOut, ifc.writeMemOut, ifc.stall} !== '0) begin
            errors++;
            $display("FAIL async_reset: result=%h dest=%0d wr=%b wm=%b stall=%b required all zero",
                     ifc.aluResultOut, ifc.destRegOut, ifc.WriteRegOut, ifc.writeMemOut, ifc.stall);
        end
        apply(mk(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        stim_t s;
        pa[0] = 32'hFFFF_FFF0; pb[0] = 32'h0000_0010;
        pa[1] = 32'h1234_5678; pb[1] = 32'h9ABC_DEF0;
        pa[2] = $urandom;      pb[2] = $urandom;
        for (int p = 0; p < 3; p++) begin
            for (int op = 0; op < 7; op++) begin
                s = mk(3'(op), pa[p], pb[p], 32'h0000_0004, 1'b0, 1'b1, 1'b0);
                s.rd = 5'(op + 1); s.m2r = op[0]; s.wm = op[1];
                drive(s, $sformatf("alu_op%0d_p%0d", op, p));
                collect();
            end
        end
        s = mk(3'b101, 32'd3, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        drive(s, "slt_imm_neg");
        collect();
    endtask

    task automatic test_beq();
        drive(mk(3'b001, 32'd7, 32'd7, 32'd3, 1'b0, 1'b0, 1'b1), "beq_taken");
        collect();
        drive(mk(3'b001, 32'd7, 32'd8, 32'd3, 1'b0, 1'b0, 1'b1), "beq_not_taken");
        collect();
    endtask

    task automatic test_mul();
        stim_t s;
        s = mk(3'b111, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        s.m2r = 1'b1;
        drive(s, "mul_ffffffff_x3");
        collect();
        drive(mk(3'b111, 32'h1234_5678, 32'd0, 32'hFFFF_FF85, 1'b1, 1'b1, 1'b0), "mul_imm_neg");
        collect();
        drive(mk(3'b111, 32'hDEAD_BEEF, 32'h0000_0009, 32'd0, 1'b0, 1'b0, 1'b0), "mul_no_write");
        collect();
    endtask

    task automatic test_back_to_back();
        drive(mk(3'b111, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b1, 1'b0), "mul_b2b_first");
        collect();
        drive(mk(3'b111, $urandom, $urandom, 32'd0, 1'b0, 1'b1, 1'b0), "mul_b2b_second");
        collect();
        drive(mk(3'b000, 32'd40, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0), "add_after_mul");
        collect();
    endtask

    task automatic test_mul_radix4();
        int n;
        ifc4.ALUCIn = 3'b111; ifc4.R1OutputIn = 32'hFFFF_FFFF; ifc4.R2OutputIn = 32'd3;
        ifc4.ALUimmIn = 1'b0; ifc4.WriteRegIn = 1'b1;
        n = 0;
        #1;
        while (ifc4.stall && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== MUL4_STALL) begin errors++; $display("FAIL radix4_stall_cycles: got %0d required %0d", n, MUL4_STALL); end
        @(posedge clk); #1;
        checks++;
        if (ifc4.aluResultOut !== 32'hFFFF_FFFD) begin errors++; $display("FAIL radix4_result: got %h required fffffffd", ifc4.aluResultOut); end
        checks++;
        if (ifc4.WriteRegOut !== 1'b1) begin errors++; $display("FAIL radix4_write: got %b required 1", ifc4.WriteRegOut); end
        @(negedge clk);
        ifc4.ALUCIn = 3'b000; ifc4.WriteRegIn = 1'b0;
    endtask

    task automatic test_rst_mid_mul();
        apply(mk(3'b111, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0));
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifc.stall, ifc.aluResultOut} !== '0) begin
            errors++;
            $display("FAIL rst_mid_run: stall=%b result=%h required 0/0", ifc.stall, ifc.aluResultOut);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(mk(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0), "add_after_rst");
        collect();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ifc.stall !== 1'b0 || ifc.aluResultOut !== 32'd2) begin
                errors++;
                $display("FAIL no_stale_mul cycle %0d: stall=%b result=%h required 0/00000002",
                         c, ifc.stall, ifc.aluResultOut);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        drive(mk(3'b000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0), "add_ovf");
        collect();
        drive(mk(3'b001, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0), "sub_ovf");
        collect();
        drive(mk(3'b000, 32'h7FFF_FFFE, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0), "add_no_ovf");
        collect();
    endtask

    initial begin
        ifc4.WriteRegIn = 1'b0; ifc4.MemToRegIn = 1'b0; ifc4.writeMemIn = 1'b0;
        ifc4.BranchIn = 1'b0; ifc4.RegrtIn = 1'b0; ifc4.ALUCIn = 3'b000; ifc4.ALUimmIn = 1'b0;
        ifc4.nextAddressIn = '0; ifc4.R1OutputIn = '0; ifc4.R2OutputIn = '0;
        ifc4.signExtendIn = '0; ifc4.rdIn = '0; ifc4.rtIn = '0;
        test_reset();
        test_alu_ops();
        test_beq();
        test_mul();
        test_back_to_back();
        test_mul_radix4();
        test_rst_mid_mul();
        test_overflow();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
